// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit-side blocks.
//   txf_state_t   : launch FSM states of uart_tx_feeder
//   TXF_FRAMES_W  : width of the launched-frame statistics counter
//   TXF_LOST_W    : width of the data_lost statistics counter
package uart_pkg;

    localparam int TXF_FRAMES_W = 16;
    localparam int TXF_LOST_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } txf_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// Single-clock circular FIFO with a registered occupancy count and
// registered FULL/EMPTY flags.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   wr_en      : write request; accepted only when not full
//   wr_data    : byte to store
//   rd_en      : pop request; honoured only when not empty
//   rd_data    : current head entry (valid while not empty)
//   full/empty : registered occupancy flags
//   count      : registered occupancy, 0..DEPTH
//   overflow   : one-cycle pulse after a write arrived while full
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic                  push;
    logic                  pop;

    // Both decisions use the flags as they stand before the edge, so a
    // write arriving while full is dropped even if a pop frees a slot.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Next occupancy: a simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Storage needs no reset; stale entries are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. Flags are
    // derived from the next count so they line up with the count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next;
            full     <= (count_next == CNT_W'(DEPTH));
            empty    <= (count_next == '0);
            overflow <= wr_en && full;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Staging buffer in front of the UART transmitter. Host bytes are queued
// in a FIFO and handed to the transmitter one at a time, only while
// busy_flag is low, so the transmitter never sees a byte it would lose.
// Ports:
//   tx_clk, rst      : clock (rising edge), asynchronous active-low reset
//   WR_DATA, WR_EN   : host write side
//   FULL, EMPTY      : FIFO occupancy flags
//   COUNT            : FIFO occupancy
//   OVERFLOW         : one-cycle pulse when a host write was dropped
//   P_DATA_OUT       : byte to transmitter, non-zero only while launching
//   DATA_VALID_OUT   : one-cycle launch strobe to transmitter
//   busy_flag        : transmitter busy
//   data_lost        : transmitter lost-byte indication
//   FRAMES_SENT      : launched byte count (UART_TXF_STATS_EN only)
//   LOST_COUNT       : data_lost cycle count (UART_TXF_STATS_EN only)
// Build option: define UART_TXF_STATS_EN to add the saturating statistics
// counters; without it data_lost is ignored.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int BUSY_WAIT  = 2
) (
    input  logic                         tx_clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        WR_DATA,
    input  logic                         WR_EN,
    output logic                         FULL,
    output logic                         EMPTY,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         OVERFLOW,
    output logic [DATA_WIDTH-1:0]        P_DATA_OUT,
    output logic                         DATA_VALID_OUT,
    input  logic                         busy_flag,
    input  logic                         data_lost
`ifdef UART_TXF_STATS_EN
    ,
    output logic [TXF_FRAMES_W-1:0]      FRAMES_SENT,
    output logic [TXF_LOST_W-1:0]        LOST_COUNT
`endif
);

    localparam int WAIT_W = $clog2(BUSY_WAIT + 1);

    txf_state_t            state_q;
    txf_state_t            state_d;
    logic                  launch;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [DATA_WIDTH-1:0] p_data_q;

    uart_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk     (tx_clk),
        .rst_n   (rst),
        .wr_en   (WR_EN),
        .wr_data (WR_DATA),
        .rd_en   (launch),
        .rd_data (fifo_head),
        .full    (FULL),
        .empty   (EMPTY),
        .count   (COUNT),
        .overflow(OVERFLOW)
    );

    // Launch FSM state register.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A launch pops the FIFO on the IDLE->LAUNCH edge;
    // WAIT_BUSY gives the transmitter BUSY_WAIT cycles to raise busy_flag
    // and otherwise treats the byte as sent.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!EMPTY && !busy_flag) begin
                    state_d = LAUNCH;
                    launch  = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_flag) begin
                    state_d = WAIT_DONE;
                end else if (wait_cnt == WAIT_W'(BUSY_WAIT - 1)) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!busy_flag) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Cycles spent in WAIT_BUSY; cleared in every other state so each
    // launch starts a fresh timeout.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state_q != WAIT_BUSY) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // The head byte is captured only on the launch edge and cleared on
    // every other edge, so it is non-zero only during LAUNCH.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            p_data_q <= '0;
        end else begin
            p_data_q <= launch ? fifo_head : '0;
        end
    end

    assign P_DATA_OUT     = p_data_q;
    assign DATA_VALID_OUT = (state_q == LAUNCH);

`ifdef UART_TXF_STATS_EN
    logic [TXF_FRAMES_W-1:0] frames_q;
    logic [TXF_LOST_W-1:0]   lost_q;

    // Saturating statistics counters.
    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            frames_q <= '0;
            lost_q   <= '0;
        end else begin
            if (launch && (frames_q != '1)) begin
                frames_q <= frames_q + TXF_FRAMES_W'(1);
            end
            if (data_lost && (lost_q != '1)) begin
                lost_q <= lost_q + TXF_LOST_W'(1);
            end
        end
    end

    assign FRAMES_SENT = frames_q;
    assign LOST_COUNT  = lost_q;
`else
    logic unused_data_lost;
    assign unused_data_lost = data_lost;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
// Self-checking bench for uart_tx_feeder. A queue holds the bytes the host
// has had accepted; every launch must deliver the queue head. A small
// transmitter model raises busy_flag one cycle after each DATA_VALID_OUT.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DW        = 8;
    localparam int DEPTH     = 8;
    localparam int BUSY_WAIT = 2;

    logic          tx_clk;
    logic          rst;
    logic [DW-1:0] WR_DATA;
    logic          WR_EN;
    logic          FULL;
    logic          EMPTY;
    logic [3:0]    COUNT;
    logic          OVERFLOW;
    logic [DW-1:0] P_DATA_OUT;
    logic          DATA_VALID_OUT;
    logic          busy_flag;
    logic          data_lost;
`ifdef UART_TXF_STATS_EN
    logic [TXF_FRAMES_W-1:0] FRAMES_SENT;
    logic [TXF_LOST_W-1:0]   LOST_COUNT;
`endif

    uart_tx_feeder #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .BUSY_WAIT (BUSY_WAIT)
    ) dut (
        .tx_clk        (tx_clk),
        .rst           (rst),
        .WR_DATA       (WR_DATA),
        .WR_EN         (WR_EN),
        .FULL          (FULL),
        .EMPTY         (EMPTY),
        .COUNT         (COUNT),
        .OVERFLOW      (OVERFLOW),
        .P_DATA_OUT    (P_DATA_OUT),
        .DATA_VALID_OUT(DATA_VALID_OUT),
        .busy_flag     (busy_flag),
        .data_lost     (data_lost)
`ifdef UART_TXF_STATS_EN
        ,
        .FRAMES_SENT   (FRAMES_SENT),
        .LOST_COUNT    (LOST_COUNT)
`endif
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    bit         ovf_exp = 0;
    int         ovf_pulses = 0;
    int         launch_cyc[$];
    bit         dv_seen = 0;
    int         busy_rem = 0;
    bit         pending = 0;
    int         frame_len = 3;
    bit         tied_low = 0;
    bit         hold_busy = 0;
    bit         rand_frames = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Runs at a falling edge: compares the outputs against the byte queue,
    // then advances the transmitter model and drives busy_flag.
    task automatic observeCycle();
        logic [7:0] want;
        cyc++;
        dv_seen = DATA_VALID_OUT;
        checkOutput("overflow", OVERFLOW, ovf_exp);
        if (OVERFLOW) ovf_pulses++;
        if (DATA_VALID_OUT) begin
            launch_cyc.push_back(cyc);
            checkOutput("launch_while_busy", busy_flag, 0);
            checkOutput("launch_has_data", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checkOutput("launch_byte", P_DATA_OUT, want);
            end
        end else begin
            checkOutput("idle_data_zero", P_DATA_OUT, 0);
        end
        checkOutput("count", COUNT, exp_q.size());
        checkOutput("empty", EMPTY, exp_q.size() == 0);
        checkOutput("full", FULL, exp_q.size() == DEPTH);

        if (pending) begin
            pending = 0;
            if (!tied_low) busy_rem = rand_frames ? int'($urandom_range(1, 6)) : frame_len;
        end
        if (DATA_VALID_OUT) pending = 1;
        busy_flag = hold_busy || (busy_rem > 0);
        if (busy_rem > 0) busy_rem--;
    endtask

    // One clock cycle: drive the host write, then observe after the edge.
    task automatic applyStimulus(input logic wr, input logic [7:0] data);
        WR_EN   = wr;
        WR_DATA = data;
        ovf_exp = 0;
        if (wr) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(data);
            else ovf_exp = 1;
        end
        @(negedge tx_clk);
        observeCycle();
    endtask

    task automatic drainQueue(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy_rem != 0 || pending) && n < budget) begin
            applyStimulus(0, 8'h00);
            n++;
        end
        checkOutput("drain_left", exp_q.size(), 0);
        repeat (6) applyStimulus(0, 8'h00);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        WR_EN     = 1'b0;
        WR_DATA   = '0;
        busy_flag = 1'b0;
        data_lost = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("reset_full", FULL, 0);
        checkOutput("reset_empty", EMPTY, 1);
        checkOutput("reset_count", COUNT, 0);
        checkOutput("reset_ovf", OVERFLOW, 0);
        checkOutput("reset_data", P_DATA_OUT, 0);
        checkOutput("reset_valid", DATA_VALID_OUT, 0);
        repeat (2) @(negedge tx_clk);
        rst = 1'b1;

        $display("[TB] single byte");
        frame_len = 3;
        applyStimulus(1, 8'hF9);
        checkOutput("latency_k", dv_seen, 0);
        applyStimulus(0, 8'h00);
        checkOutput("latency_k1", dv_seen, 1);
        checkOutput("latency_data", P_DATA_OUT, 8'hF9);
        applyStimulus(0, 8'h00);
        checkOutput("single_pulse", dv_seen, 0);
        drainQueue(100);

        $display("[TB] burst");
        frame_len = 5;
        launch_cyc.delete();
        applyStimulus(1, 8'h85);
        applyStimulus(1, 8'h0E);
        applyStimulus(1, 8'hE3);
        drainQueue(100);
        checkOutput("burst_launches", launch_cyc.size(), 3);
        if (launch_cyc.size() == 3) begin
            checkOutput("burst_gap1", launch_cyc[1] - launch_cyc[0], frame_len + 3);
            checkOutput("burst_gap2", launch_cyc[2] - launch_cyc[1], frame_len + 3);
        end

        $display("[TB] minimum spacing");
        frame_len = 1;
        launch_cyc.delete();
        applyStimulus(1, 8'h11);
        applyStimulus(1, 8'h22);
        drainQueue(100);
        checkOutput("min_launches", launch_cyc.size(), 2);
        if (launch_cyc.size() == 2)
            checkOutput("min_gap", launch_cyc[1] - launch_cyc[0], 4);

        $display("[TB] overflow");
        ovf_pulses = 0;
        hold_busy  = 1;
        busy_flag  = 1'b1;
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(8'h40 + i));
        checkOutput("full_at_depth", FULL, 1);
        checkOutput("count_at_depth", COUNT, DEPTH);
        applyStimulus(1, 8'hAA);
        applyStimulus(0, 8'h00);
        hold_busy = 0;
        busy_flag = 1'b0;
        frame_len = 2;
        drainQueue(200);
        checkOutput("ovf_pulse_count", ovf_pulses, 1);

        $display("[TB] busy timeout");
        tied_low = 1;
        launch_cyc.delete();
        applyStimulus(1, 8'h5A);
        applyStimulus(1, 8'hC3);
        drainQueue(100);
        checkOutput("to_launches", launch_cyc.size(), 2);
        if (launch_cyc.size() == 2)
            checkOutput("to_gap", launch_cyc[1] - launch_cyc[0], 2 + BUSY_WAIT);
        tied_low = 0;

        $display("[TB] random traffic");
        rand_frames = 1;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) tied_low = ($urandom_range(0, 3) == 0);
            applyStimulus(logic'($urandom_range(0, 1)), 8'($urandom));
        end
        drainQueue(300);
        rand_frames = 0;
        tied_low    = 0;

        $display("[TB] reset mid-frame");
        frame_len = 20;
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'(8'h70 + i));
        repeat (3) applyStimulus(0, 8'h00);
        checkOutput("pre_reset_count", COUNT, 3);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_rst_count", COUNT, 0);
        checkOutput("mid_rst_empty", EMPTY, 1);
        checkOutput("mid_rst_full", FULL, 0);
        checkOutput("mid_rst_ovf", OVERFLOW, 0);
        checkOutput("mid_rst_data", P_DATA_OUT, 0);
        checkOutput("mid_rst_valid", DATA_VALID_OUT, 0);
        exp_q.delete();
        ovf_exp   = 0;
        busy_rem  = 0;
        pending   = 0;
        busy_flag = 1'b0;
        WR_EN     = 1'b0;
        @(negedge tx_clk);
        rst = 1'b1;
        launch_cyc.delete();
        repeat (10) applyStimulus(0, 8'h00);
        checkOutput("post_rst_launches", launch_cyc.size(), 0);

        $display("[TB] statistics traffic");
        frame_len = 2;
        data_lost = 1'b1;
        applyStimulus(1, 8'h01);
        applyStimulus(1, 8'h02);
        data_lost = 1'b0;
        applyStimulus(1, 8'h03);
        applyStimulus(1, 8'h04);
        applyStimulus(1, 8'h05);
        drainQueue(200);
`ifdef UART_TXF_STATS_EN
        checkOutput("frames_sent", FRAMES_SENT, 5);
        checkOutput("lost_count", LOST_COUNT, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Transmit-side staging buffer sitting directly upstream of the UART transmitter, on the `tx_clk` domain. It accepts host bytes into a synchronous FIFO and feeds them one at a time into the transmitter's `P_DATA_IN` / `DATA_VALID` inputs. It only launches a byte when `busy_flag` is low, so back-to-back host writes never trigger the transmitter's `data_lost` condition.

## Interface
Parameters:
- `DATA_WIDTH`, 8, byte width; must match the transmitter.
- `DEPTH`, 8, FIFO entries; power of two, at least 2.
- `BUSY_WAIT`, 2, maximum cycles to wait for `busy_flag` to rise after a launch.

Ports (one clock; reset is asynchronous and active-low):
- `tx_clk`  in  1  transmit clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `WR_DATA`  in  DATA_WIDTH  host byte.
- `WR_EN`  in  1  host write strobe, sampled each edge.
- `FULL`  out  1  FIFO holds DEPTH entries.
- `EMPTY`  out  1  FIFO holds 0 entries.
- `COUNT`  out  $clog2(DEPTH+1)  current occupancy.
- `OVERFLOW`  out  1  one-cycle pulse: a write was dropped.
- `P_DATA_OUT`  out  DATA_WIDTH  to transmitter `P_DATA_IN`.
- `DATA_VALID_OUT`  out  1  to transmitter `DATA_VALID`.
- `busy_flag`  in  1  from transmitter.
- `data_lost`  in  1  from transmitter.
- `FRAMES_SENT`  out  16  launched-byte counter; present only with `UART_TXF_STATS_EN`.
- `LOST_COUNT`  out  8  data_lost counter; present only with `UART_TXF_STATS_EN`.

## Operation
FIFO:
- Circular buffer with read and write pointers of `$clog2(DEPTH)` bits that wrap naturally; occupancy is held in a registered count.
- Write is accepted when `WR_EN=1` and `FULL=0`, judged on the pre-edge value.
- `WR_EN=1` while `FULL=1` drops the byte and pulses `OVERFLOW`, even if a pop occurs on the same edge.
- A simultaneous accepted write and pop leaves `COUNT` unchanged.

Launch FSM states: `IDLE`, `LAUNCH`, `WAIT_BUSY`, `WAIT_DONE`.
- `IDLE` -> `LAUNCH` when `EMPTY=0` and `busy_flag=0`.
  - At that edge the head byte is registered into `P_DATA_OUT` and the read pointer advances (pop).
- `LAUNCH`: `DATA_VALID_OUT=1` for exactly this one cycle. Always -> `WAIT_BUSY`.
- `WAIT_BUSY`:
  - -> `WAIT_DONE` when `busy_flag=1`.
  - -> `IDLE` after `BUSY_WAIT` cycles without it (byte counted as sent).
- `WAIT_DONE` -> `IDLE` when `busy_flag=0`.

Other rules:
- Outside `LAUNCH`, `P_DATA_OUT` is 0 and `DATA_VALID_OUT` is 0.
- `data_lost` sampled high in any state is recorded (stats build only). The byte is not retried.
- Reset values: `FULL=0`, `EMPTY=1`, `COUNT=0`, `OVERFLOW=0`, `P_DATA_OUT=0`, `DATA_VALID_OUT=0`, counters 0, FSM in `IDLE`, pointers 0.
- Reset asserted mid-frame clears everything immediately. FIFO contents are discarded.

## Timing
- Write sampled at edge k; `EMPTY` falls after edge k.
- If idle and not busy, `DATA_VALID_OUT` is high during the cycle after edge k+1 (2-cycle latency).
- Minimum spacing between launches is 4 cycles when the transmitter raises `busy_flag` one cycle after `DATA_VALID`.
- The next launch never occurs before `busy_flag` has been observed low again, or the `WAIT_BUSY` timeout has expired.
- `COUNT`, `FULL` and `EMPTY` are registered and update on the edge after the causing event.
- Stats counters saturate at all-ones; they do not wrap.

## Configuration
- Macro: `UART_TXF_STATS_EN`.
- Defined:
  - `FRAMES_SENT` increments on each entry to `LAUNCH`.
  - `LOST_COUNT` increments on each cycle `data_lost=1`.
- Undefined: both ports and their registers are absent; `data_lost` is ignored.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `txf_state_t`.
  - Counter widths `TXF_FRAMES_W=16` and `TXF_LOST_W=8`.
- One natural sub-module, `uart_sync_fifo`, holding storage, pointers, count and flags.
  - The launch FSM and stats counters live in `uart_tx_feeder`.

## Test plan
- Single byte: after reset release, write 0xF9 once.
  - Required: `DATA_VALID_OUT` pulses one cycle 2 cycles later with `P_DATA_OUT=0xF9`.
  - Required: `EMPTY` returns to 1; the transmitter receives the byte with `data_lost=0`.
- Burst: write 0x85, 0x0E, 0xE3 on consecutive cycles.
  - Required: three launches, in order, each only after `busy_flag` falls; `data_lost` never asserts.
- Overflow: with the transmitter held busy, write DEPTH+1 bytes.
  - Required: `FULL=1` at `COUNT=8`; `OVERFLOW` pulses once; the 9th byte never appears.
- Timeout: with `busy_flag` tied 0, launch one byte.
  - Required: FSM returns to `IDLE` after 2 `WAIT_BUSY` cycles; the next byte launches.
- Reset mid-operation: with 3 bytes queued and one in `WAIT_DONE`, assert `rst=0`.
  - Required: all outputs take reset values immediately; no launch after release until a new write.
- Stats build, with `UART_TXF_STATS_EN` defined: send 5 bytes and force `data_lost` high for 2 cycles.
  - Required: `FRAMES_SENT=5`, `LOST_COUNT=2`.
